// File: rtl/scr_arbiter_pkg.sv
// Shared definitions for the scratch-RAM arbiter.
// Holds the FSM state type and the default geometry of the scratch RAM.
package scr_arbiter_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/scr_arbiter_if.sv
// Requester-side bus of the scratch arbiter.
// Two requesters (r0 = CPU, r1 = debug/DMA), each with request, write enable,
// address and write data; per-requester grant and a shared read data return.
//   master : the requesters (drive req/we/addr/din, receive gnt/rd_data)
//   slave  : the arbiter
interface scr_arbiter_if
    import scr_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_din;
    logic              r0_gnt;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_din;
    logic              r1_gnt;

    logic [DATA_W-1:0] rd_data;

    modport master (
        output r0_req, r0_we, r0_addr, r0_din,
        output r1_req, r1_we, r1_addr, r1_din,
        input  r0_gnt, r1_gnt, rd_data
    );

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_din,
        input  r1_req, r1_we, r1_addr, r1_din,
        output r0_gnt, r1_gnt, rd_data
    );

endinterface

// File: rtl/scr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : arbitration allowed this cycle (grants forced low otherwise)
//   req_i[1:0]   : requests, bit 0 = requester 0
//   gnt_o[1:0]   : one-hot grant, combinational
// The pointer names the winner on contention and flips only after a
// contended cycle that was actually arbitrated.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (en_i) begin
            unique case (req_i)
                2'b01: gnt_o = 2'b01;
                2'b10: gnt_o = 2'b10;
                2'b11: begin
                    gnt_o = ptr_q ? 2'b10 : 2'b01;
                    ptr_d = ~ptr_q;
                end
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/scr_arbiter.sv
// Scratch-RAM arbiter with whole-memory clear.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   bus            : requester bus (slave modport)
//   clr_start_i    : one-cycle pulse requesting a full clear
//   busy_o         : clear in progress
//   clr_done_o     : one-cycle pulse after the last location is cleared
//   scr_addr_o, scr_we_o, data_in_o : scratch RAM write/address port
//   data_out_i     : asynchronous scratch RAM read data
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | requesters arbitrated, granted one drives the scratch port
// ST_CLEAR | counter sweeps 0..DEPTH-1 writing zero, grants held low
module scr_arbiter
    import scr_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    scr_arbiter_if.slave      bus,
    input  logic              clr_start_i,
    output logic              busy_o,
    output logic              clr_done_o,
    output logic [ADDR_W-1:0] scr_addr_o,
    output logic              scr_we_o,
    output logic [DATA_W-1:0] data_in_o,
    input  logic [DATA_W-1:0] data_out_i
);

    // One extra bit so DEPTH == 2**ADDR_W still has a distinct last value.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t          state_q;
    logic [ADDR_W:0] cnt_q;
    logic            busy_q;
    logic            clr_done_q;
    logic            arb_en;
    logic [1:0]      gnt;

    // A clear request wins its sampling cycle outright.
    assign arb_en = (state_q == ST_IDLE) && !clr_start_i;

    rr_arb2 u_rr_arb2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (arb_en),
        .req_i ({bus.r1_req, bus.r0_req}),
        .gnt_o (gnt)
    );

    assign bus.r0_gnt  = gnt[0];
    assign bus.r1_gnt  = gnt[1];
    assign bus.rd_data = data_out_i;

    always_comb begin
        scr_addr_o = '0;
        scr_we_o   = 1'b0;
        data_in_o  = '0;
        if (state_q == ST_CLEAR) begin
            scr_addr_o = cnt_q[ADDR_W-1:0];
            scr_we_o   = 1'b1;
        end else if (gnt[0]) begin
            scr_addr_o = bus.r0_addr;
            scr_we_o   = bus.r0_we;
            data_in_o  = bus.r0_din;
        end else if (gnt[1]) begin
            scr_addr_o = bus.r1_addr;
            scr_we_o   = bus.r1_we;
            data_in_o  = bus.r1_din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (clr_start_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // clr_start_i is deliberately not looked at here.
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= '0;
                        busy_q     <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_done_o = clr_done_q;

endmodule

// File: tb/tb_scr_arbiter.sv
module tb_scr_arbiter;

    logic       clk;
    logic       rst;
    logic       clr_start;
    logic       busy;
    logic       clr_done;
    logic [7:0] scr_addr;
    logic       scr_we;
    logic [9:0] data_in;
    logic [9:0] data_out;

    logic [9:0] mem [256];
    int         ref_mem [256];

    int n_chk = 0;
    int n_err = 0;

    scr_arbiter_if #(.DATA_W(10), .ADDR_W(8)) bus ();

    scr_arbiter #(.DATA_W(10), .ADDR_W(8), .DEPTH(256)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .clr_start_i (clr_start),
        .busy_o      (busy),
        .clr_done_o  (clr_done),
        .scr_addr_o  (scr_addr),
        .scr_we_o    (scr_we),
        .data_in_o   (data_in),
        .data_out_i  (data_out)
    );

    // scratch RAM: synchronous write, asynchronous read
    always @(posedge clk) begin
        if (scr_we) mem[scr_addr] <= data_in;
    end
    assign data_out = mem[scr_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {S_GNT0, S_GNT1, S_WE, S_ADDR, S_DIN, S_RD, S_BUSY, S_DONE} sig_e;
    typedef struct {
        string tag;
        sig_e  sig;
        int    exp;
    } exp_t;

    exp_t sb[$];

    function automatic int obs(sig_e s);
        case (s)
            S_GNT0:  return int'(bus.r0_gnt);
            S_GNT1:  return int'(bus.r1_gnt);
            S_WE:    return int'(scr_we);
            S_ADDR:  return int'(scr_addr);
            S_DIN:   return int'(data_in);
            S_RD:    return int'(bus.rd_data);
            S_BUSY:  return int'(busy);
            default: return int'(clr_done);
        endcase
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input sig_e s, input int e);
        exp_t x;
        x.tag = tag;
        x.sig = s;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic exp_port(input string tag, input int g0, input int g1,
                            input int we, input int addr, input int din);
        push({tag, ".gnt0"}, S_GNT0, g0);
        push({tag, ".gnt1"}, S_GNT1, g1);
        push({tag, ".we"},   S_WE,   we);
        push({tag, ".addr"}, S_ADDR, addr);
        push({tag, ".din"},  S_DIN,  din);
    endtask

    task automatic sample();
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk(x.tag, obs(x.sig), x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r0(input bit req, input bit we, input int addr, input int din);
        bus.r0_req  = req;
        bus.r0_we   = we;
        bus.r0_addr = 8'(addr);
        bus.r0_din  = 10'(din);
    endtask

    task automatic set_r1(input bit req, input bit we, input int addr, input int din);
        bus.r1_req  = req;
        bus.r1_we   = we;
        bus.r1_addr = 8'(addr);
        bus.r1_din  = 10'(din);
    endtask

    // Entered just after a rising edge; pulses clr_start with the given
    // requests active and follows the sweep until clr_done.
    task automatic run_clear(input string tag, input bit hold_r1, input bit restart_mid);
        int busy_cnt;
        int done_cnt;
        int bad;
        int done_gnt1;
        busy_cnt  = 0;
        done_cnt  = 0;
        bad       = 0;
        done_gnt1 = 0;
        clr_start = 1'b1;
        exp_port({tag, ".start"}, 0, 0, 0, 0, 0);
        push({tag, ".start.busy"}, S_BUSY, 0);
        sample();
        tick();
        clr_start = 1'b0;
        set_r0(0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy) begin
                if (int'(scr_addr) != (busy_cnt & 255) || !scr_we || data_in != 10'd0) bad++;
                if (bus.r0_gnt || bus.r1_gnt) bad++;
                busy_cnt++;
            end
            if (clr_done) begin
                done_cnt++;
                done_gnt1 = int'(bus.r1_gnt);
                break;
            end
            tick();
            clr_start = (restart_mid && i == 50);
        end
        chk({tag, ".busy_cycles"}, busy_cnt, 256);
        chk({tag, ".done_pulses"}, done_cnt, 1);
        chk({tag, ".sweep_bad"}, bad, 0);
        if (hold_r1) chk({tag, ".r1_gnt_after"}, done_gnt1, 1);
        tick();
        set_r1(0, 0, 0, 0);
        push({tag, ".done_low"}, S_DONE, 0);
        push({tag, ".busy_low"}, S_BUSY, 0);
        sample();
        for (int a = 0; a < 256; a++) ref_mem[a] = 0;
    endtask

    task automatic read_r0(input string tag, input int addr);
        tick();
        set_r0(1, 0, addr, 0);
        exp_port(tag, 1, 0, 0, addr, 0);
        push({tag, ".rd"}, S_RD, ref_mem[addr]);
        sample();
        set_r0(0, 0, 0, 0);
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        clr_start = 1'b0;
        set_r0(0, 0, 0, 0);
        set_r1(0, 0, 0, 0);
        for (int a = 0; a < 256; a++) ref_mem[a] = 0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_port("reset", 0, 0, 0, 0, 0);
        push("reset.busy", S_BUSY, 0);
        push("reset.done", S_DONE, 0);
        sample();

        // solo write then read
        tick();
        set_r0(1, 1, 'h05, 'h3FF);
        exp_port("r0_wr", 1, 0, 1, 'h05, 'h3FF);
        sample();
        ref_mem['h05] = 'h3FF;
        tick();
        set_r0(1, 0, 'h05, 0);
        exp_port("r0_rd", 1, 0, 0, 'h05, 0);
        push("r0_rd.rd", S_RD, ref_mem['h05]);
        sample();
        tick();
        set_r0(0, 0, 0, 0);
        set_r1(1, 1, 'h22, 'h0AA);
        exp_port("r1_wr", 0, 1, 1, 'h22, 'h0AA);
        sample();
        ref_mem['h22] = 'h0AA;
        tick();
        set_r1(1, 0, 'h22, 0);
        exp_port("r1_rd", 0, 1, 0, 'h22, 0);
        push("r1_rd.rd", S_RD, ref_mem['h22]);
        sample();

        // contention straight after reset
        tick();
        set_r1(0, 0, 0, 0);
        rst = 1'b1;
        sample();
        tick();
        rst = 1'b0;
        set_r0(1, 0, 'h05, 0);
        set_r1(1, 0, 'h22, 0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                exp_port($sformatf("cont%0d", k), 1, 0, 0, 'h05, 0);
                push($sformatf("cont%0d.rd", k), S_RD, ref_mem['h05]);
            end else begin
                exp_port($sformatf("cont%0d", k), 0, 1, 0, 'h22, 0);
                push($sformatf("cont%0d.rd", k), S_RD, ref_mem['h22]);
            end
            sample();
            tick();
        end

        // contended writes: r0 wins, r1 holds and follows; pointer ends at r1
        set_r0(1, 1, 'h00, 'h155);
        set_r1(1, 1, 'hFF, 'h155);
        exp_port("cwr0", 1, 0, 1, 'h00, 'h155);
        sample();
        ref_mem['h00] = 'h155;
        tick();
        set_r0(0, 0, 0, 0);
        exp_port("cwr1", 0, 1, 1, 'hFF, 'h155);
        sample();
        ref_mem['hFF] = 'h155;
        tick();
        set_r1(0, 0, 0, 0);
        read_r0("pre_clr0", 'h00);
        read_r0("pre_clrFF", 'hFF);

        // plain clear, with r0 requesting in the start cycle
        tick();
        set_r0(1, 0, 'h00, 0);
        run_clear("clr1", 1'b0, 1'b0);
        read_r0("post_clr0", 'h00);
        read_r0("post_clrFF", 'hFF);

        // clear with r1 stalled and a mid-clear restart attempt
        tick();
        set_r1(1, 0, 'h33, 0);
        run_clear("clr2", 1'b1, 1'b1);

        // reset at clear cycle 100; pointer is at r1 going in
        tick();
        clr_start = 1'b1;
        sample();
        tick();
        clr_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            if (cnt == 100) break;
            tick();
        end
        chk("rstclr.reach", cnt, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_r0(1, 0, 'h05, 0);
        set_r1(1, 0, 'h22, 0);
        push("rstclr.busy", S_BUSY, 0);
        push("rstclr.done", S_DONE, 0);
        exp_port("rstclr.arb0", 1, 0, 0, 'h05, 0);
        sample();
        tick();
        exp_port("rstclr.arb1", 0, 1, 0, 'h22, 0);
        push("rstclr.done2", S_DONE, 0);
        sample();
        tick();
        set_r0(0, 0, 0, 0);
        set_r1(0, 0, 0, 0);
        push("rstclr.done3", S_DONE, 0);
        push("rstclr.busy3", S_BUSY, 0);
        sample();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/scr_arbiter.md
SCR_ARBITER -- requirements
Module: scr_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 10, scratch data width; ADDR_W, default 8, scratch address width; DEPTH, default 256, number of scratch locations cleared.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 R0_REQ / R1_REQ  input  1  requester 0 (CPU) and requester 1 (debug/DMA) access request.
REQ-005 R0_WE / R1_WE  input  1  request is a write (1) or a read (0).
REQ-006 R0_ADDR / R1_ADDR  input  ADDR_W  requested scratch address.
REQ-007 R0_DIN / R1_DIN  input  DATA_W  write data.
REQ-008 R0_GNT / R1_GNT  output  1  access served this cycle.
REQ-009 RD_DATA  output  DATA_W  scratch DATA_OUT, passed through to both requesters.
REQ-010 CLR_START  input  1  one-cycle pulse that requests a clear of the whole scratch RAM.
REQ-011 BUSY  output  1  clear sequence in progress.
REQ-012 CLR_DONE  output  1  one-cycle pulse when the clear completes.
REQ-013 SCR_ADDR  output  ADDR_W; SCR_WE  output  1; DATA_IN  output  DATA_W: drive the scratch RAM. DATA_OUT  input  DATA_W: asynchronous read data from the scratch RAM.

Function
REQ-014 The FSM SHALL have two states: IDLE and CLEAR.
REQ-015 In IDLE, at most one grant SHALL be asserted per cycle. Grant is combinational from the REQ inputs and the priority pointer.
REQ-016 Sole requester SHALL be granted. When both request, the requester named by the priority pointer SHALL be granted.
REQ-017 The priority pointer SHALL move to the other requester after any cycle in which both requested. Otherwise it SHALL hold.
REQ-018 The granted requester's ADDR, WE and DIN SHALL drive SCR_ADDR, SCR_WE and DATA_IN in the grant cycle.
- A write commits at the closing clock edge.
- Read data SHALL appear on RD_DATA in the same cycle (zero-latency read).
REQ-019 With no grant and not in CLEAR:
- SCR_WE SHALL be 0.
- SCR_ADDR SHALL be 0.
- DATA_IN SHALL be 0.
REQ-020 A requester not granted SHALL hold its request unchanged until granted. The arbiter SHALL NOT buffer requests.
REQ-021 CLR_START sampled in IDLE SHALL move the FSM to CLEAR on the next edge. In that sampling cycle no grant SHALL be issued.
REQ-022 In CLEAR:
- A counter SHALL run from 0 to DEPTH-1, one location per cycle.
- Each cycle drives SCR_ADDR = counter, SCR_WE = 1, DATA_IN = 0.
- BUSY = 1.
- Both grants = 0.
REQ-023 The cycle after the write to address DEPTH-1:
- The FSM SHALL return to IDLE.
- CLR_DONE SHALL pulse for exactly 1 cycle.
- BUSY SHALL fall.
- Total clear time SHALL be DEPTH cycles.
REQ-024 CLR_START during CLEAR SHALL be ignored. The clear SHALL NOT restart.
REQ-025 The counter SHALL be ADDR_W+1 bits wide so that DEPTH = 2^ADDR_W terminates without wrap-around ambiguity.

Reset
REQ-026 RST SHALL force the following on the next edge:
- State IDLE.
- Counter 0.
- Priority pointer to requester 0.
- BUSY 0, CLR_DONE 0.
REQ-027 Grants and scratch outputs SHALL follow REQ-015 to REQ-019 from the first cycle after reset.
REQ-028 RST during CLEAR SHALL abort the clear without a CLR_DONE pulse. Scratch contents are then unspecified.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, CLEAR) and the DATA_W/ADDR_W/DEPTH defaults.
REQ-030 The round-robin grant logic SHALL be one sub-module, rr_arb2: two requests in, two one-hot grants out, internal pointer register.
REQ-031 The bench SHALL instantiate scr_arbiter with the existing SCRATCH_RAM attached.

Verification
REQ-032 Solo write then read:
- Cycle 1: R0_REQ=1, R0_WE=1, ADDR=0x05, DIN=0x3FF. R0_GNT=1, SCR_WE=1.
- Cycle 2: R0 reads 0x05. RD_DATA=0x3FF in the grant cycle.
REQ-033 Contention: R0 and R1 both request reads for 4 cycles after reset.
- Grants alternate R0, R1, R0, R1.
- Never both asserted.
REQ-034 Clear: write 0x155 to addresses 0x00 and 0xFF, then pulse CLR_START.
- BUSY high for 256 cycles.
- CLR_DONE pulses once.
- Subsequent reads of 0x00 and 0xFF return 0x000.
REQ-035 Clear with stalled requesters: R1_REQ held high during CLEAR.
- R1_GNT stays 0 throughout.
- R1 is granted the first cycle after CLR_DONE.
- CLR_START pulsed mid-clear does not extend BUSY beyond 256 cycles.
REQ-036 Reset mid-clear: RST at clear cycle 100.
- Next cycle: BUSY=0, no CLR_DONE pulse.
- Priority returns to R0: simultaneous requests grant R0 first.
